adj_key_timebase: RTL and testbench

//  Upstream front end of the wall-clock core. Divides the 50 MHz board clock into a 1 ms sample tick
//  and an EN-gated 1 Hz count tick. Conditions the two raw adjust keys (hour/minute) into clean

---
 rtl/clock_pkg.sv | 28 ++
 rtl/key_channel.sv | 108 ++++++++++
 rtl/adj_key_timebase.sv | 95 +++++++++
 tb/tb_adj_key_timebase.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the wall-clock front end.
//   key_state_e : debounce/auto-repeat FSM state encoding of a key channel
//   clog2       : bits needed to index n values (minimum 1)
//   max3        : largest of three integers, used to size the key counter
package clock_pkg;

  typedef enum logic [2:0] {
    KS_IDLE     = 3'd0,
    KS_PRESS_DB = 3'd1,
    KS_HELD     = 3'd2,
    KS_REPEAT   = 3'd3,
    KS_REL_DB   = 3'd4
  } key_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One adjust-key channel: 2-FF synchroniser, debounce, single pulse per
// accepted press and auto-repeat while held. The FSM only advances on
// sample_i; pulse_o is registered and high for exactly one clock.
//   clk_i      system clock
//   rst_ni     synchronous active-low reset
//   sample_i   one-cycle sample strobe (1 ms tick)
//   key_raw_i  asynchronous key level, 1 = pressed
//   pulse_o    one-cycle increment strobe
module key_channel
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_TICKS     = 20,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sample_i,
  input  logic key_raw_i,
  output logic pulse_o
);

  localparam int CNT_W =
    clog2(max3(DEBOUNCE_TICKS, REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS) + 1);

  logic             sync1_q, sync2_q;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             pulse_q, pulse_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sample_i) begin
      unique case (state_q)
        KS_IDLE: begin
          if (sync2_q) begin
            state_d = KS_PRESS_DB;
            cnt_d   = CNT_W'(1);
          end
        end
        KS_PRESS_DB: begin
          if (!sync2_q) begin
            state_d = KS_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_W'(DEBOUNCE_TICKS)) begin
            state_d = KS_HELD;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        KS_HELD, KS_REPEAT: begin
          if (!sync2_q) begin
            state_d = KS_REL_DB;
            cnt_d   = CNT_W'(1);
          end else if (cnt_inc == ((state_q == KS_HELD) ? CNT_W'(REPEAT_DELAY_TICKS)
                                                         : CNT_W'(REPEAT_RATE_TICKS))) begin
            state_d = KS_REPEAT;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        KS_REL_DB: begin
          // A bounce back to pressed resumes the hold without a new pulse.
          if (sync2_q) begin
            state_d = KS_HELD;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_W'(DEBOUNCE_TICKS)) begin
            state_d = KS_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = KS_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= KS_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/adj_key_timebase.sv
// Front end of the wall-clock core: 1 ms sample tick, EN-gated 1 Hz tick
// and two conditioned adjust-key strobes.
//   CP50        system clock, all logic on posedge
//   nCR         synchronous active-low reset
//   EN          count enable; 0 freezes the 1 Hz divider
//   AdjH_raw    hour key, asynchronous, 1 = pressed
//   AdjM_raw    minute key, asynchronous, 1 = pressed
//   Tick1ms     one-cycle pulse every CLK_HZ/SAMPLE_HZ cycles
//   Tick1Hz     one-cycle pulse every SAMPLE_HZ sample ticks while EN=1
//   AdjH_pulse  one-cycle hour-increment strobe
//   AdjM_pulse  one-cycle minute-increment strobe
module adj_key_timebase
  import clock_pkg::*;
#(
  parameter int CLK_HZ             = 50_000_000,
  parameter int SAMPLE_HZ          = 1_000,
  parameter int DEBOUNCE_TICKS     = 20,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input  logic CP50,
  input  logic nCR,
  input  logic EN,
  input  logic AdjH_raw,
  input  logic AdjM_raw,
  output logic Tick1ms,
  output logic Tick1Hz,
  output logic AdjH_pulse,
  output logic AdjM_pulse
);

  localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_W      = clog2(SAMPLE_DIV);
  localparam int SEC_W      = clog2(SAMPLE_HZ);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic             tick1ms_q, tick1hz_q;
  logic             div_wrap, sec_wrap;

  assign div_wrap = (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
  assign sec_wrap = (sec_cnt_q == SEC_W'(SAMPLE_HZ - 1));

  // The seconds divider steps on the same strobe that sets Tick1ms, so
  // Tick1Hz lands in the same cycle as the Tick1ms that completes the second.
  always_comb begin
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    sec_cnt_d = sec_cnt_q;
    if (div_wrap && EN) begin
      sec_cnt_d = sec_wrap ? '0 : sec_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CP50) begin
    if (!nCR) begin
      div_cnt_q <= '0;
      sec_cnt_q <= '0;
      tick1ms_q <= 1'b0;
      tick1hz_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sec_cnt_q <= sec_cnt_d;
      tick1ms_q <= div_wrap;
      tick1hz_q <= div_wrap && EN && sec_wrap;
    end
  end

  assign Tick1ms = tick1ms_q;
  assign Tick1Hz = tick1hz_q;

  key_channel #(
    .DEBOUNCE_TICKS    (DEBOUNCE_TICKS),
    .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
    .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS)
  ) u_key_h (
    .clk_i    (CP50),
    .rst_ni   (nCR),
    .sample_i (tick1ms_q),
    .key_raw_i(AdjH_raw),
    .pulse_o  (AdjH_pulse)
  );

  key_channel #(
    .DEBOUNCE_TICKS    (DEBOUNCE_TICKS),
    .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
    .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS)
  ) u_key_m (
    .clk_i    (CP50),
    .rst_ni   (nCR),
    .sample_i (tick1ms_q),
    .key_raw_i(AdjM_raw),
    .pulse_o  (AdjM_pulse)
  );

endmodule

// File: tb/tb_adj_key_timebase.sv
module tb_adj_key_timebase;

  logic CP50 = 1'b0;
  logic nCR, EN, AdjH_raw, AdjM_raw;
  logic Tick1ms, Tick1Hz, AdjH_pulse, AdjM_pulse;

  adj_key_timebase #(
    .CLK_HZ(100), .SAMPLE_HZ(10), .DEBOUNCE_TICKS(3),
    .REPEAT_DELAY_TICKS(5), .REPEAT_RATE_TICKS(2)
  ) dut (
    .CP50(CP50), .nCR(nCR), .EN(EN), .AdjH_raw(AdjH_raw), .AdjM_raw(AdjM_raw),
    .Tick1ms(Tick1ms), .Tick1Hz(Tick1Hz), .AdjH_pulse(AdjH_pulse), .AdjM_pulse(AdjM_pulse)
  );

  always #5 CP50 = ~CP50;

  int cyc = 0;
  always @(posedge CP50) cyc <= cyc + 1;

  // Pulse logs (absolute cycle numbers) and width-violation counter.
  int ms_q[$], hz_q[$], h_q[$], m_q[$];
  int wv = 0;
  logic p_ms = 1'b0, p_hz = 1'b0, p_h = 1'b0, p_m = 1'b0;
  always @(negedge CP50) begin
    if (Tick1ms)    ms_q.push_back(cyc);
    if (Tick1Hz)    hz_q.push_back(cyc);
    if (AdjH_pulse) h_q.push_back(cyc);
    if (AdjM_pulse) m_q.push_back(cyc);
    if ((Tick1ms && p_ms) || (Tick1Hz && p_hz) || (AdjH_pulse && p_h) || (AdjM_pulse && p_m))
      wv <= wv + 1;
    p_ms <= Tick1ms; p_hz <= Tick1Hz; p_h <= AdjH_pulse; p_m <= AdjM_pulse;
  end

  int tests = 0, fails = 0;
  int base = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CP50);
    #1;
  endtask

  task automatic clear_logs();
    ms_q.delete(); hz_q.delete(); h_q.delete(); m_q.delete();
  endtask

  function automatic logic [3:0] outs();
    return {Tick1ms, Tick1Hz, AdjH_pulse, AdjM_pulse};
  endfunction

  task automatic do_reset();
    nCR = 1'b0;
    step();
    check("reset_outs_edge1", int'(outs()), 0);
    step();
    check("reset_outs_edge2", int'(outs()), 0);
    nCR = 1'b1;
    base = cyc;
    clear_logs();
  endtask

  task automatic wait_rel(input int r);
    while (cyc - base < r) step();
  endtask

  // Stops in the cycle where Tick1ms is visible; t = that cycle.
  task automatic wait_tick(output int t);
    t = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (Tick1ms) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("wait_tick_timeout", 0, 1);
  endtask

  typedef struct {
    int   rel;
    logic en;
    logic exp_ms;
    logic exp_hz;
  } vec_t;

  vec_t vecs[11];
  int   exp_m_rel[5];

  initial begin
    int t, lat, settle;

    vecs[0]  = '{9,   1'b1, 1'b0, 1'b0};
    vecs[1]  = '{10,  1'b1, 1'b1, 1'b0};
    vecs[2]  = '{11,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{20,  1'b1, 1'b1, 1'b0};
    vecs[4]  = '{50,  1'b1, 1'b1, 1'b0};
    vecs[5]  = '{99,  1'b1, 1'b0, 1'b0};
    vecs[6]  = '{100, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{101, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{150, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{200, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{201, 1'b1, 1'b0, 1'b0};
    exp_m_rel = '{31, 81, 101, 121, 141};

    nCR = 1'b0; EN = 1'b1; AdjH_raw = 1'b0; AdjM_raw = 1'b0;

    // Timebase after reset
    do_reset();
    foreach (vecs[i]) begin
      wait_rel(vecs[i].rel);
      EN = vecs[i].en;
      check($sformatf("tick1ms@%0d", vecs[i].rel), int'(Tick1ms), int'(vecs[i].exp_ms));
      check($sformatf("tick1hz@%0d", vecs[i].rel), int'(Tick1Hz), int'(vecs[i].exp_hz));
    end
    wait_rel(205);
    check("ms_count_205", ms_q.size(), 20);
    check("hz_count_205", hz_q.size(), 2);
    check("hz_first_rel", (hz_q.size() > 0) ? hz_q[0] - base : -1, 100);

    // Bouncing hour key then a clean hold
    clear_logs();
    for (int i = 0; i < 40; i++) begin
      AdjH_raw = (((i / 3) % 2) == 0);
      step();
    end
    AdjH_raw = 1'b1;
    settle = cyc;
    repeat (60) step();
    AdjH_raw = 1'b0;
    repeat (80) step();
    check("bounce_h_count", h_q.size(), 1);
    check("bounce_m_count", m_q.size(), 0);
    lat = (h_q.size() > 0) ? h_q[0] - settle : -1;
    check("bounce_latency_ok", int'(lat >= 1 && lat <= 43), 1);

    // Minute key held with auto-repeat
    clear_logs();
    wait_tick(t);
    AdjM_raw = 1'b1;
    while (cyc - t < 150) step();
    AdjM_raw = 1'b0;
    repeat (80) step();
    check("repeat_m_count", m_q.size(), 5);
    foreach (exp_m_rel[i])
      check($sformatf("repeat_m_pulse%0d", i), (m_q.size() > i) ? m_q[i] - t : -1, exp_m_rel[i]);
    check("repeat_h_count", h_q.size(), 0);

    // Simultaneous presses
    clear_logs();
    wait_tick(t);
    AdjH_raw = 1'b1; AdjM_raw = 1'b1;
    repeat (40) step();
    AdjH_raw = 1'b0; AdjM_raw = 1'b0;
    repeat (80) step();
    check("simul_h_count", h_q.size(), 1);
    check("simul_m_count", m_q.size(), 1);
    check("simul_h_rel", (h_q.size() > 0) ? h_q[0] - t : -1, 31);
    check("simul_same_cycle", (h_q.size() > 0 && m_q.size() > 0) ? h_q[0] - m_q[0] : -1, 0);

    // EN pauses the 1 Hz divider only
    do_reset();
    wait_rel(150);
    EN = 1'b0;
    check("en_hz_before_pause", hz_q.size(), 1);
    wait_rel(400);
    check("en_ms_keeps_running", ms_q.size(), 40);
    check("en_hz_absent", hz_q.size(), 1);
    EN = 1'b1;
    wait_rel(460);
    check("en_hz_count_after", hz_q.size(), 2);
    check("en_hz_resume_rel", (hz_q.size() > 1) ? hz_q[1] - base : -1, 450);

    // Reset while the hour key is repeating
    clear_logs();
    wait_tick(t);
    AdjH_raw = 1'b1;
    while (cyc - t < 89) step();
    check("pre_reset_h_pulses", h_q.size(), 2);
    nCR = 1'b0;
    step();
    check("mid_reset_outs", int'(outs()), 0);
    nCR = 1'b1;
    base = cyc;
    clear_logs();
    wait_rel(85);
    AdjH_raw = 1'b0;
    check("post_reset_tick_rel", (ms_q.size() > 0) ? ms_q[0] - base : -1, 10);
    check("post_reset_h_count", h_q.size(), 2);
    check("post_reset_press_rel", (h_q.size() > 0) ? h_q[0] - base : -1, 31);
    check("post_reset_repeat_rel", (h_q.size() > 1) ? h_q[1] - base : -1, 81);
    repeat (60) step();

    check("pulse_width_violations", wv, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
